serializer_flat: RTL and testbench



---
 rtl/serializer_flat.sv | 82 ++++++++
 tb/tb_serializer_flat.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serializer_flat.sv
// Flat-to-stream serializer: accepts one packed block of N_SAMPLES words on a
// wide val/rdy port and replays it one BIT_WIDTH word per handshake.
module serializer_flat #(
    parameter int BIT_WIDTH = 32,
    parameter int N_SAMPLES = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [BIT_WIDTH*N_SAMPLES-1:0] recv_msg,
    input  logic                           recv_val,
    output logic                           recv_rdy,
    output logic [BIT_WIDTH-1:0]           send_msg,
    output logic                           send_val,
    input  logic                           send_rdy
);

    // Handshakes: a transfer happens on a rising edge where val && rdy; rdy
    // never depends combinationally on val, and val depends only on state.

    localparam int CNT_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_WIDTH-1:0] blk_q [N_SAMPLES];
    logic [BIT_WIDTH-1:0] blk_d [N_SAMPLES];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        blk_d    = blk_q;
        recv_rdy = 1'b0;
        send_val = 1'b0;
        send_msg = '0;
        case (state_q)
            IDLE: begin
                recv_rdy = !reset;
                if (recv_val && recv_rdy) begin
                    for (int i = 0; i < N_SAMPLES; i++) begin
                        blk_d[i] = recv_msg[BIT_WIDTH*i +: BIT_WIDTH];
                    end
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                send_val = 1'b1;
                send_msg = blk_q[cnt_q];
                if (send_val && send_rdy) begin
                    // Explicit wrap so non-power-of-2 block sizes never overrun.
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < N_SAMPLES; i++) begin
                blk_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
        end
    end

endmodule

// File: tb/tb_serializer_flat.sv
// Scoreboard bench for serializer_flat: directed blocks, backpressure, reset
// abort, a single-sample instance, and a randomized loopback reassembly.
module tb_serializer_flat;

    localparam int BW = 32;
    localparam int NS = 8;
    localparam int FW = BW * NS;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [FW-1:0] recv_msg = '0;
    logic          recv_val = 1'b0;
    logic          recv_rdy;
    logic [BW-1:0] send_msg;
    logic          send_val;
    logic          send_rdy = 1'b0;

    logic [15:0]   r1_msg = '0;
    logic          r1_val = 1'b0;
    logic          r1_rdy;
    logic [15:0]   s1_msg;
    logic          s1_val;
    logic          s1_rdy = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [BW-1:0] exp_q[$];
    logic [FW-1:0] blk_exp_q[$];
    bit            lb_en = 1'b0;
    int            lb_idx = 0;
    int            lb_blocks = 0;
    logic [FW-1:0] lb_flat = '0;
    int            rdy_mode = 0;

    serializer_flat #(.BIT_WIDTH(BW), .N_SAMPLES(NS)) u_dut (
        .clk(clk), .reset(reset),
        .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(recv_rdy),
        .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy)
    );

    serializer_flat #(.BIT_WIDTH(16), .N_SAMPLES(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .recv_msg(r1_msg), .recv_val(r1_val), .recv_rdy(r1_rdy),
        .send_msg(s1_msg), .send_val(s1_val), .send_rdy(s1_rdy)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk_block(input logic [BW-1:0] base);
        logic [FW-1:0] b;
        b = '0;
        for (int i = 0; i < NS; i++) b[BW*i +: BW] = base + BW'(i);
        return b;
    endfunction

    // send_rdy driver: 0 = always high, 1 = fixed pattern, 2 = random
    initial begin
        bit [6:0] pat;
        int pidx;
        pat = 7'b1101001;   // applied LSB first: 1,0,0,1,0,1,1
        pidx = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: send_rdy = 1'b1;
                1: begin
                    send_rdy = pat[pidx % 7];
                    pidx++;
                end
                default: send_rdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor / scoreboard: every SEND cycle must show the head of exp_q.
    always @(negedge clk) begin
        logic [BW-1:0] w;
        if (!reset && send_val) begin
            check("recv_rdy_during_send", recv_rdy, 0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word: got %0h expected none", send_msg);
            end else begin
                check("send_msg", send_msg, exp_q[0]);
                if (send_rdy) begin
                    w = exp_q.pop_front();
                    if (lb_en) begin
                        lb_flat[BW*lb_idx +: BW] = send_msg;
                        lb_idx++;
                        if (lb_idx == NS) begin
                            lb_idx = 0;
                            lb_blocks++;
                            if (blk_exp_q.size() == 0) begin
                                checks++;
                                failures++;
                                $display("FAIL loopback_extra_block: got %0h expected none", lb_flat);
                            end else begin
                                check("loopback_block", lb_flat, blk_exp_q.pop_front());
                            end
                        end
                    end
                end
            end
        end
    end

    // Driver: called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic send_block(input logic [FW-1:0] blk, input bit keep_val, output int waited);
        bit ok;
        ok = 1'b0;
        waited = 0;
        recv_msg = blk;
        recv_val = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (recv_rdy) begin
                ok = 1'b1;
                break;
            end
            waited++;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got no recv_rdy expected accept");
            recv_val = 1'b0;
        end else begin
            @(posedge clk);
            for (int i = 0; i < NS; i++) exp_q.push_back(blk[BW*i +: BW]);
            if (lb_en) blk_exp_q.push_back(blk);
            #1;
            if (!keep_val) recv_val = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name, output int cycles);
        bit ok;
        ok = 1'b0;
        cycles = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !send_val) begin
                ok = 1'b1;
                break;
            end
            cycles++;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s_drain_timeout: got %0d words left expected 0", name, exp_q.size());
        end
        check({name, "_idle_send_val"}, send_val, 0);
        check({name, "_idle_send_msg"}, send_msg, 0);
        check({name, "_idle_recv_rdy"}, recv_rdy, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int waited;
        int cycles;
        logic [FW-1:0] blk;

        // Reset held together with recv_val: nothing may be latched.
        reset = 1'b1;
        recv_val = 1'b1;
        recv_msg = mk_block(32'h5500);
        r1_val = 1'b1;
        r1_msg = 16'h1234;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_recv_rdy", recv_rdy, 0);
        check("reset_r1_rdy", r1_rdy, 0);
        check("reset_send_val", send_val, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        recv_val = 1'b0;
        r1_val = 1'b0;
        r1_msg = '0;
        @(negedge clk);
        check("post_reset_send_val", send_val, 0);
        check("post_reset_send_msg", send_msg, 0);
        check("post_reset_recv_rdy", recv_rdy, 1);
        check("post_reset_s1_val", s1_val, 0);
        @(posedge clk);
        #1;

        // 1: samples 0..7 with send_rdy held high
        rdy_mode = 0;
        @(posedge clk);
        #1;
        send_block(mk_block(32'h0), 1'b0, waited);
        check("t1_accept_wait", waited, 0);
        wait_drain("t1", cycles);
        check("t1_send_cycles", cycles, NS);

        // 2: same block under a stalling send_rdy pattern
        rdy_mode = 1;
        @(posedge clk);
        #1;
        send_block(mk_block(32'h0), 1'b0, waited);
        wait_drain("t2", cycles);

        // 3: back-to-back blocks with recv_val held high
        rdy_mode = 0;
        @(posedge clk);
        #1;
        send_block(mk_block(32'hA0), 1'b1, waited);
        send_block(mk_block(32'hB0), 1'b0, waited);
        check("t3_second_accept_wait", waited, NS);
        wait_drain("t3", cycles);

        // 4: reset after three samples aborts the block
        send_block(mk_block(32'hC0), 1'b0, waited);
        repeat (3) @(posedge clk);
        #1;
        check("t4_words_left_at_reset", exp_q.size(), NS - 3);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("t4_send_val", send_val, 0);
        check("t4_send_msg", send_msg, 0);
        check("t4_recv_rdy", recv_rdy, 1);
        @(posedge clk);
        #1;
        send_block(mk_block(32'hD0), 1'b0, waited);
        check("t4_accept_wait", waited, 0);
        wait_drain("t4", cycles);

        // 5: single-sample 16-bit instance
        r1_msg = 16'hBEEF;
        r1_val = 1'b1;
        s1_rdy = 1'b1;
        @(negedge clk);
        check("t5_recv_rdy", r1_rdy, 1);
        check("t5_idle_val", s1_val, 0);
        @(posedge clk);
        #1;
        r1_val = 1'b0;
        r1_msg = '0;
        @(negedge clk);
        check("t5_send_val", s1_val, 1);
        check("t5_send_msg", s1_msg, 16'hBEEF);
        check("t5_busy_rdy", r1_rdy, 0);
        @(negedge clk);
        check("t5_after_val", s1_val, 0);
        check("t5_after_msg", s1_msg, 0);
        check("t5_after_rdy", r1_rdy, 1);
        @(posedge clk);
        #1;

        // 6: loopback reassembly, random data and gaps
        lb_en = 1'b1;
        rdy_mode = 2;
        for (int b = 0; b < 100; b++) begin
            for (int i = 0; i < NS; i++) blk[BW*i +: BW] = $urandom;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            send_block(blk, 1'b0, waited);
        end
        wait_drain("t6", cycles);
        check("t6_blocks", lb_blocks, 100);
        check("t6_pending_blocks", blk_exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
